// File: rtl/elm_pkg.sv
// Shared defaults and FSM encoding for the ELM output-layer datapath.
package elm_pkg;
  localparam int N_HID_DEF   = 20;
  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = 40;
  localparam int MUL_LAT_DEF = 2;
  localparam int IDX_W       = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/elm_mul_pipe.sv
// Signed DATA_W x DATA_W multiplier with a MUL_LAT-deep register pipeline.
// A valid bit travels alongside each product.
module elm_mul_pipe #(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod,
  output logic                  out_vld,
  output logic                  pend
);

  logic [2*DATA_W-1:0] stage_q [MUL_LAT];
  logic [MUL_LAT-1:0]  vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) stage_q[i] <= '0;
      vld_q <= '0;
    end else begin
      stage_q[0] <= $signed(a) * $signed(b);
      vld_q[0]   <= in_vld;
      for (int i = 1; i < MUL_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
        vld_q[i]   <= vld_q[i-1];
      end
    end
  end

  // Anything still in flight ahead of the output stage.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < MUL_LAT - 1; i++) pend = pend | vld_q[i];
  end

  assign prod    = stage_q[MUL_LAT-1];
  assign out_vld = vld_q[MUL_LAT-1];

endmodule

// File: rtl/w21_output_mac.sv
// Dot product of hidden activations with W21 weights for one output neuron.
// state | meaning
// IDLE  | accumulator cleared, index at 1, waiting for start
// FETCH | reading index 1..N_HID, one pair per cycle
// DRAIN | waiting for the last product to be accumulated
// DONE  | result valid, done pulse
module w21_output_mac
  import elm_pkg::*;
#(
  parameter int N_HID   = N_HID_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] act_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic                rd_v_q;
  logic [2*DATA_W-1:0] prod;
  logic                prod_vld;
  logic                pipe_pend;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    result_q;
  logic [ACC_W-1:0]    prod_ext;

  elm_mul_pipe #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_v_q),
    .a       (act_in),
    .b       (w_in),
    .prod    (prod),
    .out_vld (prod_vld),
    .pend    (pipe_pend)
  );

  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: if (idx_q == IDX_W'(N_HID)) state_d = ST_DRAIN;
      // Leave only once the final product is the sole valid in the chain.
      ST_DRAIN: if (prod_vld && !rd_v_q && !pipe_pend) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rd_v_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      rd_v_q  <= (state_q == ST_FETCH);

      if (state_q == ST_IDLE)
        idx_q <= IDX_W'(1);
      else if (state_q == ST_FETCH && idx_q != IDX_W'(N_HID))
        idx_q <= idx_q + IDX_W'(1);

      if (state_q == ST_IDLE)
        acc_q <= '0;
      else if (prod_vld)
        acc_q <= acc_q + prod_ext;

      if (state_q == ST_DONE)
        result_q <= acc_q;
    end
  end

  assign rd_en  = (state_q == ST_FETCH);
  assign rd_idx = (state_q == ST_FETCH) ? idx_q : '0;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = (state_q == ST_DONE) ? acc_q : result_q;

endmodule

// File: tb/tb_w21_output_mac.sv
// Directed bench for w21_output_mac with a one-cycle-latency memory model.
module tb_w21_output_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rd_en;
  logic [4:0]  rd_idx;
  logic [15:0] act_in = '0;
  logic [15:0] w_in = '0;
  logic        busy;
  logic        done;
  logic [39:0] result;

  logic [15:0] act_mem [1:20];
  logic [15:0] w_mem [1:20];

  int tests_run = 0;
  int tests_failed = 0;

  w21_output_mac dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .act_in (act_in),
    .w_in   (w_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Memories answer one cycle after rd_en; junk otherwise.
  always @(posedge clk) begin
    if (rd_en && rd_idx >= 5'd1 && rd_idx <= 5'd20) begin
      act_in <= act_mem[rd_idx];
      w_in   <= w_mem[rd_idx];
    end else begin
      act_in <= 16'($urandom);
      w_in   <= 16'($urandom);
    end
  end

  task automatic load_unit();
    for (int k = 1; k <= 20; k++) begin
      act_mem[k] = 16'sd1;
      w_mem[k]   = 16'sd1;
    end
  endtask

  task automatic load_signed();
    for (int k = 1; k <= 20; k++) begin
      act_mem[k] = 16'(k);
      w_mem[k]   = (k % 2 == 1) ? 16'hFFFF : 16'd2;
    end
  endtask

  task automatic load_extreme();
    for (int k = 1; k <= 20; k++) begin
      act_mem[k] = 16'h8000;
      w_mem[k]   = 16'h8000;
    end
  endtask

  // Starts a computation (cycle 0) and watches ncyc cycles. Extra start
  // pulses are raised during cycles s1/s2/s3. Sequence errors are counted
  // over cycles 1..25 of the first computation.
  task automatic run(input int s1, input int s2, input int s3, input int ncyc,
                     output int dcnt, output int d1, output int d2,
                     output logic [39:0] r1, output logic [39:0] r2,
                     output int idx_err, output int busy_err);
    dcnt = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0; idx_err = 0; busy_err = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      start = (cyc == s1 || cyc == s2 || cyc == s3);
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = cyc; r1 = result; end
        if (dcnt == 2) begin d2 = cyc; r2 = result; end
      end
      if (cyc <= 25) begin
        if (rd_en !== (cyc <= 20)) idx_err++;
        if (rd_idx !== ((cyc <= 20) ? 5'(cyc) : 5'd0)) idx_err++;
        if (busy !== (cyc <= 24)) busy_err++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++;
    if (rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en got %0b want 0", rd_en); end
    tests_run++;
    if (rd_idx !== 5'd0) begin tests_failed++; $display("FAIL reset_rd_idx got %0d want 0", rd_idx); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
    tests_run++;
    if (result !== 40'd0) begin tests_failed++; $display("FAIL reset_result got %0d want 0", result); end
  endtask

  task automatic test_unit();
    int dcnt, d1, d2, ie, be;
    logic [39:0] r1, r2;
    load_unit();
    run(-1, -1, -1, 30, dcnt, d1, d2, r1, r2, ie, be);
    tests_run++;
    if (r1 !== 40'd20) begin tests_failed++; $display("FAIL unit_result got %0d want 20", $signed(r1)); end
    tests_run++;
    if (d1 !== 24) begin tests_failed++; $display("FAIL unit_done_cycle got %0d want 24", d1); end
    tests_run++;
    if (dcnt !== 1) begin tests_failed++; $display("FAIL unit_done_count got %0d want 1", dcnt); end
    tests_run++;
    if (ie !== 0) begin tests_failed++; $display("FAIL unit_rd_idx_seq errors %0d want 0", ie); end
    tests_run++;
    if (be !== 0) begin tests_failed++; $display("FAIL unit_busy errors %0d want 0", be); end
  endtask

  task automatic test_signed();
    int dcnt, d1, d2, ie, be;
    logic [39:0] r1, r2;
    load_signed();
    run(-1, -1, -1, 30, dcnt, d1, d2, r1, r2, ie, be);
    tests_run++;
    if (r1 !== 40'd120) begin tests_failed++; $display("FAIL signed_result got %0d want 120", $signed(r1)); end
    tests_run++;
    if (d1 !== 24) begin tests_failed++; $display("FAIL signed_done_cycle got %0d want 24", d1); end
  endtask

  task automatic test_extremes();
    int dcnt, d1, d2, ie, be;
    logic [39:0] r1, r2;
    load_extreme();
    run(-1, -1, -1, 30, dcnt, d1, d2, r1, r2, ie, be);
    tests_run++;
    if (r1 !== 40'd21474836480) begin
      tests_failed++; $display("FAIL extreme_result got %0d want 21474836480", $signed(r1));
    end
  endtask

  task automatic test_busy_start();
    int dcnt, d1, d2, ie, be;
    logic [39:0] r1, r2;
    load_unit();
    run(5, 24, 25, 60, dcnt, d1, d2, r1, r2, ie, be);
    tests_run++;
    if (d1 !== 24) begin tests_failed++; $display("FAIL busy_first_done got %0d want 24", d1); end
    tests_run++;
    if (ie !== 0 || be !== 0) begin
      tests_failed++; $display("FAIL busy_ignored_starts seq_err %0d busy_err %0d want 0 0", ie, be);
    end
    tests_run++;
    if (dcnt !== 2) begin tests_failed++; $display("FAIL busy_done_count got %0d want 2", dcnt); end
    tests_run++;
    if (d2 !== 49) begin tests_failed++; $display("FAIL busy_second_done got %0d want 49", d2); end
    tests_run++;
    if (r2 !== 40'd20) begin tests_failed++; $display("FAIL busy_second_result got %0d want 20", $signed(r2)); end
  endtask

  task automatic test_reset_mid();
    int dcnt, d1, d2, ie, be, late_done;
    logic [39:0] r1, r2;
    load_unit();
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || rd_idx !== 5'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_ctrl got busy=%0b rd_en=%0b rd_idx=%0d done=%0b want 0 0 0 0",
               busy, rd_en, rd_idx, done);
    end
    tests_run++;
    if (result !== 40'd0) begin tests_failed++; $display("FAIL midreset_result got %0d want 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) late_done++;
    end
    tests_run++;
    if (late_done !== 0) begin tests_failed++; $display("FAIL midreset_no_done got %0d pulses want 0", late_done); end
    load_signed();
    run(-1, -1, -1, 30, dcnt, d1, d2, r1, r2, ie, be);
    tests_run++;
    if (r1 !== 40'd120 || d1 !== 24) begin
      tests_failed++; $display("FAIL midreset_rerun got %0d at cycle %0d want 120 at 24", $signed(r1), d1);
    end
  endtask

  task automatic test_hold();
    int dcnt, d1, d2, ie, be, dpulse, changes;
    logic [39:0] r1, r2;
    load_extreme();
    run(-1, -1, -1, 26, dcnt, d1, d2, r1, r2, ie, be);
    dpulse = 0; changes = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (done) dpulse++;
      if (result !== 40'd21474836480) changes++;
    end
    tests_run++;
    if (dpulse !== 0) begin tests_failed++; $display("FAIL hold_done got %0d pulses want 0", dpulse); end
    tests_run++;
    if (changes !== 0) begin
      tests_failed++; $display("FAIL hold_result got %0d, %0d unstable cycles, want 21474836480", $signed(result), changes);
    end
  endtask

  initial begin
    for (int k = 1; k <= 20; k++) begin act_mem[k] = '0; w_mem[k] = '0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_unit();
    test_signed();
    test_extremes();
    test_busy_start();
    test_reset_mid();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
